// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: fetch and data ports share one word-wide memory port.
// Big-endian sub-word stores/loads, misalignment trapping, and a 2-deep data-fairness counter.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_sb,
    input  logic        d_sh,
    input  logic        d_lb,
    input  logic        d_lh,
    input  logic        d_load_ext,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_req,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t      state, state_nxt;
    logic [1:0]  data_run;
    logic        grant_d, grant_f, done;

    size_t       d_size, lat_size;
    logic        d_mis, f_mis;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic        lat_wr, lat_ext, lat_mis;
    logic [1:0]  lat_off;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_val;

    assign stall = d_req & ~d_ack;
    assign f_mis = (if_addr[1:0] != 2'b00);
    assign done  = ((state == DATA) || (state == FETCH)) && (lat_mis || m_ack);

    // Store flags select the size for writes, load flags for reads.
    always_comb begin
        d_size = SZ_W;
        if (d_wr ? d_sb : d_lb)
            d_size = SZ_B;
        else if (d_wr ? d_sh : d_lh)
            d_size = SZ_H;
        d_mis = ((d_size == SZ_H) && d_addr[0]) ||
                ((d_size == SZ_W) && (d_addr[1:0] != 2'b00));
    end

    always_comb begin
        st_wdata = d_wdata;
        st_be    = 4'b1111;
        if (d_size == SZ_B) begin
            st_wdata = {4{d_wdata[7:0]}};
            st_be    = 4'b1000 >> d_addr[1:0];
        end else if (d_size == SZ_H) begin
            st_wdata = {2{d_wdata[15:0]}};
            st_be    = d_addr[1] ? 4'b0011 : 4'b1100;
        end
    end

    // Big-endian lane pick: offset 0 lives in the top byte.
    always_comb begin
        lane_b = m_rdata[7:0];
        case (lat_off)
            2'd0:    lane_b = m_rdata[31:24];
            2'd1:    lane_b = m_rdata[23:16];
            2'd2:    lane_b = m_rdata[15:8];
            default: lane_b = m_rdata[7:0];
        endcase
        lane_h = lat_off[1] ? m_rdata[15:0] : m_rdata[31:16];
        ld_val = m_rdata;
        case (lat_size)
            SZ_B:    ld_val = {{24{lat_ext & lane_b[7]}}, lane_b};
            SZ_H:    ld_val = {{16{lat_ext & lane_h[15]}}, lane_h};
            default: ld_val = m_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_f   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !((data_run == 2'd2) && if_req)) begin
                    grant_d   = 1'b1;
                    state_nxt = DATA;
                end else if (if_req) begin
                    grant_f   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DATA, FETCH: if (lat_mis || m_ack) state_nxt = RESP;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_run <= 2'd0;
            m_req    <= 1'b0;
            m_wr     <= 1'b0;
            m_addr   <= 32'd0;
            m_wdata  <= 32'd0;
            m_be     <= 4'd0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
            if_rdata <= 32'd0;
            d_rdata  <= 32'd0;
            lat_wr   <= 1'b0;
            lat_ext  <= 1'b0;
            lat_mis  <= 1'b0;
            lat_off  <= 2'd0;
            lat_size <= SZ_B;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            if (grant_d) begin
                data_run <= (data_run == 2'd2) ? 2'd2 : data_run + 2'd1;
                m_req    <= ~d_mis;
                m_wr     <= d_wr;
                m_addr   <= {d_addr[31:2], 2'b00};
                m_wdata  <= st_wdata;
                m_be     <= d_wr ? st_be : 4'b1111;
                lat_wr   <= d_wr;
                lat_ext  <= d_load_ext;
                lat_mis  <= d_mis;
                lat_off  <= d_addr[1:0];
                lat_size <= d_size;
            end else if (grant_f) begin
                data_run <= 2'd0;
                m_req    <= ~f_mis;
                m_wr     <= 1'b0;
                m_addr   <= {if_addr[31:2], 2'b00};
                m_be     <= 4'b1111;
                lat_wr   <= 1'b0;
                lat_mis  <= f_mis;
                lat_size <= SZ_W;
            end
            if (done) begin
                m_req <= 1'b0;
                if (state == DATA) begin
                    d_ack <= 1'b1;
                    d_err <= lat_mis;
                    // Stores and trapped accesses leave the last load result in place.
                    if (!lat_mis && !lat_wr)
                        d_rdata <= ld_val;
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= lat_mis ? 32'd0 : m_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timeline reference model of grants/acks, directed cases
// with literal expectations, then randomized traffic with stray memory acks.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, d_req, d_wr, d_sb, d_sh, d_lb, d_lh, d_load_ext, m_ack;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_ack, d_ack, d_err, m_req, m_wr, stall;
    logic [3:0]  m_be;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_sb(d_sb), .d_sh(d_sh), .d_lb(d_lb), .d_lh(d_lh), .d_load_ext(d_load_ext),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall)
    );

    always #5 clk = ~clk;

    // sz: 0 byte, 1 half, 2 word; rdata/dly describe the memory's answer to this request
    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  sz;
        logic        ext;
        logic [31:0] rdata;
        int          dly;
    } req_t;

    int   total = 0, bad = 0;
    int   t = 0;
    req_t dq[$], fq[$];
    req_t dc, fc, g;
    logic dv = 1'b0, fv = 1'b0, mis = 1'b0, dir = 1'b1, rst_pend = 1'b0, chk_en = 1'b0;
    int   run = 0, gs = -10, ms = -10, me = -10, ack_t = -10, free_at = 0, mack_force = 0;

    logic        e_mreq = 0, e_dack = 0, e_iack = 0, e_derr = 0, e_stall = 0, e_wr = 0;
    logic [31:0] e_drd = 0, e_ird = 0, e_addr = 0, e_wdata = 0;
    logic [3:0]  e_be = 0;

    logic        saw_mreq, s_wr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, t);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", nm, t);
    endtask

    function automatic logic is_mis(input req_t r);
        return ((r.sz == 2'd1) && r.addr[0]) || ((r.sz == 2'd2) && (r.addr[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] load_val(input req_t r);
        logic [31:0] s;
        logic [7:0]  b;
        logic [15:0] h;
        if (r.sz == 2'd2) return r.rdata;
        if (r.sz == 2'd0) begin
            s = r.rdata >> (8 * (3 - r.addr[1:0]));
            b = s[7:0];
            return r.ext ? {{24{b[7]}}, b} : {24'd0, b};
        end
        s = r.rdata >> (16 * (1 - r.addr[1]));
        h = s[15:0];
        return r.ext ? {{16{h[15]}}, h} : {16'd0, h};
    endfunction

    function automatic void mem_exp(input req_t r, output logic w, output logic [31:0] a,
                                    output logic [31:0] wd, output logic [3:0] be);
        w  = r.is_d && r.wr;
        a  = {r.addr[31:2], 2'b00};
        wd = r.wdata;
        be = 4'hF;
        if (w && r.sz == 2'd0) begin
            wd = {4{r.wdata[7:0]}};
            be = 4'b1000 >> r.addr[1:0];
        end else if (w && r.sz == 2'd1) begin
            wd = {2{r.wdata[15:0]}};
            be = r.addr[1] ? 4'b0011 : 4'b1100;
        end
    endfunction

    function automatic req_t mk(input logic is_d, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] sz, input logic ext,
                                input logic [31:0] rdata, input int dly);
        req_t r;
        r.is_d = is_d; r.wr = wr; r.addr = addr; r.wdata = wdata;
        r.sz = sz; r.ext = ext; r.rdata = rdata; r.dly = dly;
        return r;
    endfunction

    function automatic req_t rnd_req(input logic is_d);
        req_t r;
        r = mk(is_d, is_d && ($urandom_range(0, 1) == 1), $urandom, $urandom,
               is_d ? 2'($urandom_range(0, 2)) : 2'd2, 1'($urandom_range(0, 1)),
               $urandom, $urandom_range(0, 3));
        if ($urandom_range(0, 4) != 0) begin
            if (r.sz == 2'd2) r.addr[1:0] = 2'b00;
            if (r.sz == 2'd1) r.addr[0] = 1'b0;
        end
        return r;
    endfunction

    // One clock of the reference: requesters, memory responder and the arbitration timeline.
    task automatic cycle(input logic do_rst);
        logic take_d, inwin;
        @(posedge clk);
        #1;
        t++;
        if (rst_pend) begin
            rst_pend = 0; rst_n = 1'b1;
            run = 0; gs = -10; ms = -10; me = -10; ack_t = -10; free_at = t;
            e_drd = 0; e_ird = 0; dv = 0; fv = 0;
        end else if (t - 1 == ack_t) begin
            if (g.is_d) dv = 0; else fv = 0;
        end
        if (!dv && dq.size() > 0 && (dir || $urandom_range(0, 2) != 0)) begin
            dc = dq.pop_front(); dv = 1;
        end
        if (!fv && fq.size() > 0 && (dir || $urandom_range(0, 2) != 0)) begin
            fc = fq.pop_front(); fv = 1;
        end
        if (do_rst) begin
            rst_n = 1'b0; rst_pend = 1;
        end
        d_req = dv; d_wr = dc.wr; d_addr = dc.addr; d_wdata = dc.wdata; d_load_ext = dc.ext;
        d_sb = dc.wr && dc.sz == 2'd0; d_sh = dc.wr && dc.sz == 2'd1;
        d_lb = !dc.wr && dc.sz == 2'd0; d_lh = !dc.wr && dc.sz == 2'd1;
        if_req = fv; if_addr = fc.addr;

        inwin   = (t > gs) && (t < ack_t);
        m_ack   = (t == me) || (mack_force > 0) || (!dir && !inwin && $urandom_range(0, 3) == 0);
        m_rdata = (t == me) ? g.rdata : $urandom;
        if (mack_force > 0) mack_force--;

        if (!do_rst && t >= free_at && (dv || fv)) begin
            take_d = dv && !(run == 2 && fv);
            if (take_d) begin
                g = dc; run = (run == 2) ? 2 : run + 1;
            end else begin
                g = fc; run = 0;
            end
            gs  = t;
            mis = is_mis(g);
            if (mis) begin
                ms = -10; me = -10; ack_t = t + 2;
            end else begin
                ms = t + 1; me = t + 1 + g.dly; ack_t = me + 1;
            end
            free_at = ack_t + 1;
            mem_exp(g, e_wr, e_addr, e_wdata, e_be);
        end

        e_mreq = (t >= ms) && (t <= me);
        e_dack = (t == ack_t) && g.is_d;
        e_iack = (t == ack_t) && !g.is_d;
        e_derr = e_dack && mis;
        if (t == ack_t) begin
            if (g.is_d) begin
                if (!mis && !g.wr) e_drd = load_val(g);
            end else begin
                e_ird = mis ? 32'd0 : g.rdata;
            end
        end
        e_stall = dv && !e_dack;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req", m_req, e_mreq);
            chk("d_ack", d_ack, e_dack);
            chk("if_ack", if_ack, e_iack);
            chk("d_err", d_err, e_derr);
            chk("stall", stall, e_stall);
            chk("d_rdata", d_rdata, e_drd);
            chk("if_rdata", if_rdata, e_ird);
            if (e_mreq) begin
                chk("m_addr", m_addr, e_addr);
                chk("m_be", m_be, e_be);
                chk("m_wr", m_wr, e_wr);
                if (e_wr) chk("m_wdata", m_wdata, e_wdata);
            end
        end
    end

    task automatic wait_ack(input logic want_d, input int bound, output int cyc);
        cyc = -1;
        saw_mreq = 0;
        for (int i = 0; i < bound; i++) begin
            cycle(0);
            @(negedge clk);
            if (m_req) begin
                saw_mreq = 1; s_addr = m_addr; s_wdata = m_wdata; s_be = m_be; s_wr = m_wr;
            end
            if (want_d ? d_ack : if_ack) begin
                cyc = t;
                break;
            end
        end
        if (cyc < 0) timeout("wait_ack");
    endtask

    task automatic drain(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (dq.size() == 0 && fq.size() == 0 && !dv && !fv && t >= free_at) break;
            cycle(0);
        end
        if (i >= bound) timeout("drain");
    endtask

    initial begin
        int   cyc, t0, n, last;
        logic [5:0] pat;
        dc = mk(1, 0, 0, 0, 2, 0, 0, 0);
        fc = mk(0, 0, 0, 0, 2, 0, 0, 0);
        g  = dc;
        d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0; d_sb = 0; d_sh = 0; d_lb = 0; d_lh = 0;
        d_load_ext = 0; if_req = 0; if_addr = 0; m_ack = 0; m_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_wr", m_wr, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_be", m_be, 0);
        chk("rst_acks", {if_ack, d_ack, d_err}, 0);
        chk("rst_rdata", d_rdata | if_rdata, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Byte load at offset 1, zero- then sign-extended; memory acks 2 cycles after m_req.
        dq.push_back(mk(1, 0, 32'h1001, 0, 0, 0, 32'h11A2B3C4, 2));
        t0 = t + 1;
        wait_ack(1, 20, cyc);
        chk("lbu_latency", cyc - t0, 4);
        chk("lbu_data", d_rdata, 32'h000000A2);
        chk("lbu_err", d_err, 0);
        dq.push_back(mk(1, 0, 32'h1001, 0, 0, 1, 32'h11A2B3C4, 2));
        t0 = t + 1;
        wait_ack(1, 20, cyc);
        chk("lb_latency", cyc - t0, 4);
        chk("lb_data", d_rdata, 32'hFFFFFFA2);

        dq.push_back(mk(1, 1, 32'h2002, 32'h0000BEEF, 1, 0, 32'h0, 1));
        wait_ack(1, 20, cyc);
        chk("sh_saw_mreq", saw_mreq, 1);
        chk("sh_addr", s_addr, 32'h00002000);
        chk("sh_wdata", s_wdata, 32'hBEEFBEEF);
        chk("sh_be", s_be, 4'b0011);
        chk("sh_wr", s_wr, 1);
        chk("sh_err", d_err, 0);

        dq.push_back(mk(1, 0, 32'h3001, 0, 2, 0, 32'h12345678, 0));
        t0 = t + 1;
        wait_ack(1, 20, cyc);
        chk("lw_mis_latency", cyc - t0, 2);
        chk("lw_mis_err", d_err, 1);
        chk("lw_mis_no_mreq", saw_mreq, 0);

        // Reset while the memory access is outstanding; late acks must be ignored.
        dq.push_back(mk(1, 0, 32'h4000, 0, 2, 0, 32'hDEADBEEF, 6));
        repeat (3) cycle(0);
        cycle(1);
        mack_force = 2;
        cycle(0);
        @(negedge clk);
        chk("abort_m_req", m_req, 0);
        chk("abort_m_fields", m_addr | m_wdata, 0);
        chk("abort_m_be_wr", {m_be, m_wr}, 0);
        chk("abort_acks", {if_ack, d_ack, d_err}, 0);
        chk("abort_rdata", d_rdata | if_rdata, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0);
            @(negedge clk);
            chk("abort_late_ack", d_ack, 0);
        end

        // Both requesters held busy: two data grants then one fetch, repeating.
        for (int i = 0; i < 6; i++) begin
            dq.push_back(mk(1, 0, $urandom & 32'hFFFFFFFC, 0, 2, 0, $urandom, $urandom_range(0, 2)));
            fq.push_back(mk(0, 0, $urandom & 32'hFFFFFFFC, 0, 2, 0, $urandom, $urandom_range(0, 2)));
        end
        n = 0; pat = 0; last = -10;
        for (int i = 0; i < 200 && n < 6; i++) begin
            cycle(0);
            @(negedge clk);
            if (d_ack || if_ack) begin
                pat = {pat[4:0], d_ack};
                if (n > 0) chk("ack_gap", (t - last) >= 2, 1);
                n++;
                last = t;
            end
        end
        if (n < 6) timeout("grant_order");
        chk("grant_order", pat, 6'b110110);
        drain(500);

        dir = 0;
        for (int i = 0; i < 150; i++) begin
            dq.push_back(rnd_req(1));
            fq.push_back(rnd_req(0));
        end
        drain(20000);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
